// File: rtl/mac_feeder_pkg.sv
// Shared constants, FSM state type and tap-to-byte mapping for the 3x3 MAC feeder.
package mac_feeder_pkg;

  localparam int unsigned KW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned WIN_W = KW * KW * DW;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Byte lane of kernel tap (i, j); lane 0 is top-left, lane 8 the newest pixel.
  function automatic int unsigned tap_idx(input int unsigned i, input int unsigned j);
    return i * KW + j;
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Pixel/weight input and MAC-facing output bundle of the feeder.
interface mac_feeder_if;
  import mac_feeder_pkg::*;

  logic             w_ld;
  logic [WIN_W-1:0] w_data;
  logic             sof;
  logic             pix_vld;
  logic [DW-1:0]    pix;
  logic             vld_o;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] din;
  logic             busy;
  logic             frame_done;

  modport master (
    output w_ld, w_data, sof, pix_vld, pix,
    input  vld_o, win, din, busy, frame_done
  );

  modport slave (
    input  w_ld, w_data, sof, pix_vld, pix,
    output vld_o, win, din, busy, frame_done
  );

endinterface

// File: rtl/mac_feeder_line_buffer.sv
// One-row pixel delay: a Depth-deep shift register advanced only on accepted pixels.
module mac_feeder_line_buffer
  import mac_feeder_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < Depth; k++) mem_q[k] <= '0;
    end else if (en) begin
      mem_q[0] <= din;
      for (int unsigned k = 1; k < Depth; k++) mem_q[k] <= mem_q[k-1];
    end
  end

  assign dout = mem_q[Depth-1];

endmodule

// File: rtl/mac_feeder.sv
// Raster pixel stream to 3x3 window feeder for the MAC.
// Build option: STRIDE2_EN emits only windows completed at even (row, col).
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16
) (
  input logic         clk,
  input logic         rstn,
  mac_feeder_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, cur_c;
  logic [RW-1:0]    row_q, row_d, cur_r;
  logic             accept, last, emit, load_w, stride_ok;
  logic [DW-1:0]    row1_pix, row2_pix;
  logic [DW-1:0]    tap [KW];
  logic [DW-1:0]    col0_q [KW];
  logic [DW-1:0]    col1_q [KW];
  logic [WIN_W-1:0] win_q, din_q, din_d;
  logic             vld_q, done_q;

  mac_feeder_line_buffer #(.Depth(WIDTH)) u_lb_row1 (
    .clk  (clk),
    .rstn (rstn),
    .en   (accept),
    .din  (bus.pix),
    .dout (row1_pix)
  );

  mac_feeder_line_buffer #(.Depth(WIDTH)) u_lb_row2 (
    .clk  (clk),
    .rstn (rstn),
    .en   (accept),
    .din  (row1_pix),
    .dout (row2_pix)
  );

  assign tap[0] = row2_pix;
  assign tap[1] = row1_pix;
  assign tap[2] = bus.pix;

`ifdef STRIDE2_EN
  assign stride_ok = ~cur_r[0] & ~cur_c[0];
`else
  assign stride_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    load_w  = 1'b0;
    accept  = 1'b0;
    // sof always names pixel (0,0), whether starting or restarting a frame
    cur_c   = bus.sof ? '0 : col_q;
    cur_r   = bus.sof ? '0 : row_q;
    unique case (state_q)
      StIdle: begin
        load_w = bus.w_ld;
        accept = bus.pix_vld & bus.sof;
      end
      StRun:   accept = bus.pix_vld;
      default: ;
    endcase
    last = accept && (cur_r == RowLast) && (cur_c == ColLast);
    emit = accept && (cur_r >= RW'(2)) && (cur_c >= CW'(2)) && stride_ok;
    if (accept) begin
      if (last) begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = StRun;
        if (cur_c == ColLast) begin
          col_d = '0;
          row_d = cur_r + RW'(1);
        end else begin
          col_d = cur_c + CW'(1);
          row_d = cur_r;
        end
      end
    end
  end

  // Columns c-2 and c-1 live in registers; column c comes straight from the taps.
  always_comb begin
    din_d = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      din_d[tap_idx(i, 0)*DW +: DW] = col0_q[i];
      din_d[tap_idx(i, 1)*DW +: DW] = col1_q[i];
      din_d[tap_idx(i, 2)*DW +: DW] = tap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      din_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < KW; i++) begin
        col0_q[i] <= '0;
        col1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= emit;
      done_q  <= accept && last;
      if (load_w) win_q <= bus.w_data;
      if (emit)   din_q <= din_d;
      if (accept) begin
        for (int unsigned i = 0; i < KW; i++) begin
          col0_q[i] <= col1_q[i];
          col1_q[i] <= tap[i];
        end
      end
    end
  end

  assign bus.vld_o      = vld_q;
  assign bus.win        = win_q;
  assign bus.din        = din_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a window scoreboard built from a frame image model.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

`ifdef STRIDE2_EN
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NWIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NWIN = (W - 2) * (H - 2);
`endif

  localparam logic [71:0] W0 = 72'h090807060504030201;
  localparam logic [71:0] W2 = 72'h112233445566778899;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mac_feeder_if bus ();

  mac_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          m_run;
  int          m_r, m_c;
  logic [71:0] m_win, hold_din, first_din, last_din;
  logic [7:0]  img [H][W];
  logic [71:0] exp_q [$];
  int          nwin, ndone;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit emits(input int r, input int c);
`ifdef STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  // One clock: update the model, apply inputs, then check outputs after the edge.
  task automatic drive(input bit pv, input bit s, input logic [7:0] px, input bit wld,
                       input logic [71:0] wd);
    bit          ev, ed;
    int          r, c;
    logic [71:0] w;
    ev = 1'b0;
    ed = 1'b0;
    if (!m_run && wld) m_win = wd;
    if (pv && (m_run || s)) begin
      r = s ? 0 : m_r;
      c = s ? 0 : m_c;
      img[r][c] = px;
      if (emits(r, c)) begin
        ev = 1'b1;
        w  = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) w[(3*i+j)*8 +: 8] = img[r-2+i][c-2+j];
        exp_q.push_back(w);
      end
      if (r == H - 1 && c == W - 1) begin
        ed = 1'b1; m_run = 1'b0; m_r = 0; m_c = 0;
      end else begin
        m_run = 1'b1;
        m_r   = (c == W - 1) ? r + 1 : r;
        m_c   = (c == W - 1) ? 0 : c + 1;
      end
    end
    bus.pix_vld = pv;
    bus.sof     = s;
    bus.pix     = px;
    bus.w_ld    = wld;
    bus.w_data  = wd;
    @(posedge clk);
    #1;
    check("vld_o", bus.vld_o, ev);
    check("frame_done", bus.frame_done, ed);
    check("busy", bus.busy, m_run);
    check("win", bus.win, m_win);
    if (bus.vld_o) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) hold_din = exp_q.pop_front();
      if (nwin == 0) first_din = bus.din;
      nwin++;
    end
    check("din", bus.din, hold_din);
    if (bus.frame_done) begin
      ndone++;
      last_din = bus.din;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'($urandom), 1'b0, '0);
  endtask

  // gap: 0 back to back, 1 alternate idle cycles, 2 random stalls.
  task automatic send_frame(input int gap, input int npix, input bit wl0,
                            input logic [71:0] wd0, input bit wlmid);
    int k;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k >= npix) return;
        drive(1'b1, k == 0, 8'(r * W + c + 1), (k == 0) ? wl0 : wlmid,
              (k == 0) ? wd0 : {72{1'b1}});
        k++;
        if (gap == 1) idle();
        if (gap == 2) repeat ($urandom_range(0, 2)) idle();
      end
    end
  endtask

  task automatic do_reset(input bit pv, input logic [7:0] px);
    rstn        = 1'b0;
    bus.pix_vld = pv;
    bus.sof     = 1'b0;
    bus.pix     = px;
    bus.w_ld    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_vld_o", bus.vld_o, 0);
    check("rst_din", bus.din, 0);
    check("rst_win", bus.win, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    rstn     = 1'b1;
    m_run    = 1'b0;
    m_r      = 0;
    m_c      = 0;
    m_win    = '0;
    hold_din = '0;
    exp_q.delete();
  endtask

  task automatic start_count();
    nwin  = 0;
    ndone = 0;
  endtask

  task automatic end_frame(input string tag);
    repeat (2) idle();
    check({tag, "_nwin"}, nwin, NWIN);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    bus.w_ld    = 1'b0;
    bus.w_data  = '0;
    bus.sof     = 1'b0;
    bus.pix_vld = 1'b0;
    bus.pix     = '0;
    do_reset(1'b0, 8'h00);

    drive(1'b0, 1'b0, 8'h00, 1'b1, W0);
    check("win_load", bus.win, W0);
    repeat (3) drive(1'b1, 1'b0, 8'h55, 1'b0, '0);

    start_count();
    send_frame(0, W * H, 1'b0, '0, 1'b0);
    end_frame("basic");
`ifndef STRIDE2_EN
    check("basic_first_din", first_din, 72'h0B0A09070605030201);
    check("basic_last_din", last_din, 72'h100F0E0C0B0A080706);
`endif
    check("basic_win_kept", bus.win, W0);

    start_count();
    send_frame(1, W * H, 1'b0, '0, 1'b0);
    end_frame("toggle");
    start_count();
    send_frame(2, W * H, 1'b0, '0, 1'b0);
    end_frame("stall");
`ifndef STRIDE2_EN
    check("stall_last_din", last_din, 72'h100F0E0C0B0A080706);
`endif

    start_count();
    send_frame(0, W + 4, 1'b0, '0, 1'b0);
    send_frame(0, W * H, 1'b0, '0, 1'b0);
    end_frame("restart");

    start_count();
    send_frame(0, W * H, 1'b0, '0, 1'b1);
    end_frame("wld_run");
    check("wld_run_win", bus.win, W0);

    start_count();
    send_frame(2, W * H, 1'b1, W2, 1'b0);
    end_frame("wld_sof");
    check("wld_sof_win", bus.win, W2);

    start_count();
    send_frame(0, 2 * W + 3, 1'b0, '0, 1'b0);
    do_reset(1'b1, 8'(2 * W + 4));
    start_count();
    send_frame(0, W * H, 1'b0, '0, 1'b0);
    end_frame("post_rst");
    check("post_rst_win", bus.win, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
